// File: rtl/radix4_booth_seq_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_mult_pkg;

    // Controller states: waiting for operands, retiring digits, holding the product
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of radix-4 Booth digits needed for an n-bit operand extended to n+2 bits
    function automatic int digit_count(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/radix4_booth_seq_mult_digit_pp.sv
// Radix-4 Booth digit encoder and partial-product row generator.
// The row is returned in one's-complement form for negative digits; the
// caller adds the correction bit at the row LSB to complete the negation.
module booth_digit_pp #(
    parameter int XW = 14
) (
    input  logic [2:0]    bits,
    input  logic [XW-1:0] x_ext,
    output logic [XW:0]   row,
    output logic          corr
);

    // Decode the three multiplier bits into a signed multiple of X
    always_comb begin
        logic [XW:0] mag;
        logic        neg;
        mag = '0;
        neg = 1'b0;
        case (bits)
            3'b001, 3'b010: mag = {x_ext[XW-1], x_ext};
            3'b011:         mag = {x_ext, 1'b0};
            3'b100: begin
                mag = {x_ext, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {x_ext[XW-1], x_ext};
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
        row  = neg ? ~mag : mag;
        corr = neg;
    end

endmodule

// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, valid/ready
// handshakes on both sides, synchronous flush.
module radix4_booth_seq_mult
    import booth_mult_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 12
) (
    input  logic                        _clk,
    input  logic                        _rstN,
    input  logic                        _validIn,
    output logic                        _readyOut,
    input  logic [NUMBER_OF_BITS-1:0]   _xin,
    input  logic [NUMBER_OF_BITS-1:0]   _yin,
    input  logic                        _signedMode,
    input  logic                        _flushIn,
    output logic                        _validOut,
    input  logic                        _readyIn,
    output logic [2*NUMBER_OF_BITS-1:0] _productOut,
    output logic                        _busyOut
);

    // NUMBER_OF_BITS must be even and at least 4 so every digit window fits.
    localparam int N  = NUMBER_OF_BITS;
    localparam int XW = N + 2;
    localparam int AW = 2 * N + 2;
    localparam int D  = digit_count(N);
    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    state_t          state_reg;
    logic [XW-1:0]   x_reg;
    logic [XW-1:0]   y_reg;
    logic [CW-1:0]   cnt_reg;
    logic [AW-1:0]   acc_reg;
    logic            ready_reg;
    logic            valid_reg;
    logic            busy_reg;

    logic [XW:0]     y_pad;
    logic [2:0]      digit_bits;
    logic [XW:0]     row;
    logic            corr;
    logic [AW-1:0]   row_ext;
    logic [AW-1:0]   addend;
    logic [XW-1:0]   x_ext_in;
    logic [XW-1:0]   y_ext_in;

    // Extend incoming operands by two bits so unsigned values stay positive under Booth recoding
    always_comb begin
        x_ext_in = _signedMode ? {{2{_xin[N-1]}}, _xin} : {2'b00, _xin};
        y_ext_in = _signedMode ? {{2{_yin[N-1]}}, _yin} : {2'b00, _yin};
    end

    // Select the current digit window (2i+1, 2i, 2i-1) with an implicit zero below bit 0
    always_comb begin
        y_pad      = {y_reg, 1'b0};
        digit_bits = 3'(y_pad >> {cnt_reg, 1'b0});
    end

    booth_digit_pp #(
        .XW (XW)
    ) u_digit_pp (
        .bits  (digit_bits),
        .x_ext (x_reg),
        .row   (row),
        .corr  (corr)
    );

    // Sign-extend the row, complete the negation and place it at weight 4^i
    always_comb begin
        row_ext = {{(AW - XW - 1){row[XW]}}, row};
        addend  = (row_ext + AW'(corr)) << {cnt_reg, 1'b0};
    end

    // Controller, digit counter and accumulator with registered handshake outputs
    always_ff @(posedge _clk or negedge _rstN) begin
        if (!_rstN) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (_validIn) begin
                        x_reg     <= x_ext_in;
                        y_reg     <= y_ext_in;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        state_reg <= CALC;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                CALC: begin
                    if (_flushIn) begin
                        state_reg <= IDLE;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b0;
                    end else begin
                        acc_reg <= acc_reg + addend;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_DIGIT) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (_flushIn || _readyIn) begin
                        state_reg <= IDLE;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign _readyOut   = ready_reg;
    assign _validOut   = valid_reg;
    assign _busyOut    = busy_reg;
    assign _productOut = valid_reg ? acc_reg[2*N-1:0] : '0;

endmodule
